// File: rtl/lector_mascara_pkg.sv
// rtl/lector_mascara_pkg.sv - shared state encoding and mask-size constants for lector_mascara
package lector_mascara_pkg;

    typedef enum logic [1:0] {
        REPOSO,
        LEYENDO,
        DRENANDO,
        LISTO
    } estado_t;

    localparam int TAM_MASCARA_3 = 3;
    localparam int TAM_MASCARA_5 = 5;
    localparam int NUM_COEF_3    = 9;
    localparam int NUM_COEF_5    = 25;

endpackage

// File: rtl/lector_mascara_banco_coeficientes.sv
// rtl/lector_mascara_banco_coeficientes.sv - coefficient register bank with clear and indexed write
module banco_coeficientes #(
    parameter int  BITS_DATO        = 8,
    parameter int  MAX_COEFICIENTES = 25,
    localparam int BITS_INDICE      = $clog2(MAX_COEFICIENTES)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  limpiar,
    input  logic                                  escritura,
    input  logic [BITS_INDICE-1:0]                indice,
    input  logic [BITS_DATO-1:0]                  dato,
    output logic [MAX_COEFICIENTES*BITS_DATO-1:0] coeficientes
);

    logic [BITS_DATO-1:0] banco [MAX_COEFICIENTES];

    // Clear has priority over a capture landing on the same edge
    always_ff @(posedge clk) begin
        if (reset || limpiar) begin
            for (int k = 0; k < MAX_COEFICIENTES; k++) begin
                banco[k] <= '0;
            end
        end else if (escritura && (32'(indice) < MAX_COEFICIENTES)) begin
            banco[indice] <= dato;
        end
    end

    // Row-major packing: slot k occupies bits [k*BITS_DATO +: BITS_DATO]
    always_comb begin
        coeficientes = '0;
        for (int k = 0; k < MAX_COEFICIENTES; k++) begin
            coeficientes[k*BITS_DATO +: BITS_DATO] = banco[k];
        end
    end

endmodule

// File: rtl/registro_d.sv
// rtl/registro_d.sv - enabled D flip-flop register with synchronous active-high reset
module registro_d #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             habilitacion,
    input  logic [ANCHO-1:0] d,
    output logic [ANCHO-1:0] q
);

    // Load d when enabled, hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (habilitacion) begin
            q <= d;
        end
    end

endmodule

// File: rtl/lector_mascara.sv
// rtl/lector_mascara.sv - fetches 3x3 or 5x5 convolution mask coefficients from mask memory
module lector_mascara
    import lector_mascara_pkg::*;
#(
    parameter int BITS_DIRECCION_MEM = 10,
    parameter int BITS_MASCARA       = 3,
    parameter int BITS_DATO          = 8,
    parameter int MAX_COEFICIENTES   = 25
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  inicio,
    input  logic [BITS_DIRECCION_MEM-1:0]         direccion_mem_inicio_mascara,
    input  logic [BITS_MASCARA-1:0]               tamano_mascara,
    output logic [BITS_DIRECCION_MEM-1:0]         mem_direccion,
    output logic                                  mem_lectura,
    input  logic [BITS_DATO-1:0]                  mem_datos,
    output logic [MAX_COEFICIENTES*BITS_DATO-1:0] coeficientes,
    output logic                                  mascara_lista,
    output logic                                  ocupado,
    output logic                                  error_tamano
);

    localparam int BITS_INDICE = $clog2(MAX_COEFICIENTES);

    estado_t                       estado;
    logic [BITS_DIRECCION_MEM-1:0] base_q;
    logic [BITS_MASCARA-1:0]       tam_q;
    logic [BITS_INDICE-1:0]        indice;
    logic [BITS_INDICE-1:0]        indice_d;
    logic [BITS_INDICE-1:0]        indice_sig;
    logic [BITS_INDICE-1:0]        ultimo;
    logic                          lectura_d;
    logic                          tam_valido;

    registro_d #(.ANCHO(BITS_DIRECCION_MEM)) u_base (
        .clk          (clk),
        .reset        (reset),
        .habilitacion (inicio),
        .d            (direccion_mem_inicio_mascara),
        .q            (base_q)
    );

    registro_d #(.ANCHO(BITS_MASCARA)) u_tamano (
        .clk          (clk),
        .reset        (reset),
        .habilitacion (inicio),
        .d            (tamano_mascara),
        .q            (tam_q)
    );

    // Size legality on the incoming request and last read index for the latched size
    always_comb begin
        tam_valido = (tamano_mascara == BITS_MASCARA'(TAM_MASCARA_3)) ||
                     (tamano_mascara == BITS_MASCARA'(TAM_MASCARA_5));
        ultimo     = (tam_q == BITS_MASCARA'(TAM_MASCARA_5)) ? BITS_INDICE'(NUM_COEF_5 - 1)
                                                             : BITS_INDICE'(NUM_COEF_3 - 1);
        indice_sig = indice + 1'b1;
    end

    // Fetch sequencer; the delayed read flag/index qualify the memory's one-cycle-late data
    always_ff @(posedge clk) begin
        if (reset) begin
            estado        <= REPOSO;
            mem_lectura   <= 1'b0;
            mem_direccion <= '0;
            indice        <= '0;
            indice_d      <= '0;
            lectura_d     <= 1'b0;
            mascara_lista <= 1'b0;
            ocupado       <= 1'b0;
            error_tamano  <= 1'b0;
        end else begin
            error_tamano <= 1'b0;
            lectura_d    <= mem_lectura;
            indice_d     <= indice;
            if (inicio) begin
                // A new request drops the read in flight so it cannot land in the fresh bank
                lectura_d     <= 1'b0;
                mascara_lista <= 1'b0;
                indice        <= '0;
                if (tam_valido) begin
                    estado        <= LEYENDO;
                    mem_lectura   <= 1'b1;
                    mem_direccion <= direccion_mem_inicio_mascara;
                    ocupado       <= 1'b1;
                end else begin
                    estado       <= REPOSO;
                    mem_lectura  <= 1'b0;
                    ocupado      <= 1'b0;
                    error_tamano <= 1'b1;
                end
            end else begin
                case (estado)
                    LEYENDO: begin
                        if (indice == ultimo) begin
                            estado      <= DRENANDO;
                            mem_lectura <= 1'b0;
                        end else begin
                            indice        <= indice_sig;
                            mem_direccion <= base_q + BITS_DIRECCION_MEM'(indice_sig);
                        end
                    end
                    DRENANDO: begin
                        estado        <= LISTO;
                        ocupado       <= 1'b0;
                        mascara_lista <= 1'b1;
                    end
                    REPOSO, LISTO: begin
                    end
                    default: begin
                        estado <= REPOSO;
                    end
                endcase
            end
        end
    end

    banco_coeficientes #(
        .BITS_DATO        (BITS_DATO),
        .MAX_COEFICIENTES (MAX_COEFICIENTES)
    ) u_banco (
        .clk          (clk),
        .reset        (reset),
        .limpiar      (inicio),
        .escritura    (lectura_d),
        .indice       (indice_d),
        .dato         (mem_datos),
        .coeficientes (coeficientes)
    );

endmodule

// File: tb/tb_lector_mascara.sv
// tb/tb_lector_mascara.sv - self-checking bench for lector_mascara with address scoreboard
module tb_lector_mascara;

    logic         clk = 1'b0;
    logic         reset;
    logic         inicio;
    logic [9:0]   direccion_mem_inicio_mascara;
    logic [2:0]   tamano_mascara;
    logic [9:0]   mem_direccion;
    logic         mem_lectura;
    logic [7:0]   mem_datos;
    logic [199:0] coeficientes;
    logic         mascara_lista;
    logic         ocupado;
    logic         error_tamano;

    int           num_checks  = 0;
    int           num_errores = 0;
    int           lecturas    = 0;
    logic [9:0]   exp_dir [$];

    lector_mascara dut (
        .clk                          (clk),
        .reset                        (reset),
        .inicio                       (inicio),
        .direccion_mem_inicio_mascara (direccion_mem_inicio_mascara),
        .tamano_mascara               (tamano_mascara),
        .mem_direccion                (mem_direccion),
        .mem_lectura                  (mem_lectura),
        .mem_datos                    (mem_datos),
        .coeficientes                 (coeficientes),
        .mascara_lista                (mascara_lista),
        .ocupado                      (ocupado),
        .error_tamano                 (error_tamano)
    );

    always #5 clk = ~clk;

    // Mask memory: word = low byte of address, junk when not read
    always @(posedge clk) begin
        if (mem_lectura) mem_datos <= mem_direccion[7:0];
        else             mem_datos <= 8'hEE;
    end

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        num_checks++;
        if (obs !== esp) begin
            num_errores++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, esp);
        end
    endtask

    // Every issued read must match the head of the expected-address queue
    always @(negedge clk) begin
        if (mem_lectura) begin
            lecturas++;
            if (exp_dir.size() == 0) comprobar("lectura_inesperada", {22'd0, mem_direccion}, 32'hFFFF_FFFF);
            else                     comprobar("direccion", {22'd0, mem_direccion}, {22'd0, exp_dir.pop_front()});
        end
    end

    task automatic disparar(input logic [9:0] base, input logic [2:0] tam);
        logic [9:0] a;
        @(negedge clk);
        #1;
        direccion_mem_inicio_mascara = base;
        tamano_mascara = tam;
        inicio = 1'b1;
        exp_dir.delete();
        lecturas = 0;
        if (tam == 3'd3 || tam == 3'd5) begin
            for (int i = 0; i < ((tam == 3'd3) ? 9 : 25); i++) begin
                a = base + 10'(i);
                exp_dir.push_back(a);
            end
        end
        @(posedge clk);
        #1;
        inicio = 1'b0;
    endtask

    task automatic esperar_lista(input int n, input bit verificar_limpio);
        int e;
        bit vista;
        e = 0;
        vista = 0;
        while (e < 60) begin
            @(negedge clk);
            if (e == 0 && verificar_limpio) begin
                comprobar("lista_cae", {31'd0, mascara_lista}, 32'd0);
                comprobar("banco_limpio", {31'd0, |coeficientes}, 32'd0);
            end
            if (mascara_lista) begin
                vista = 1;
                break;
            end
            @(posedge clk);
            e++;
        end
        comprobar("flancos_hasta_lista", vista ? e : 999, n + 1);
        comprobar("num_lecturas", lecturas, n);
        comprobar("cola_vacia", exp_dir.size(), 0);
        comprobar("ocupado_listo", {31'd0, ocupado}, 32'd0);
    endtask

    task automatic verificar_banco(input logic [9:0] base, input int n);
        logic [9:0] a;
        logic [7:0] esp;
        for (int i = 0; i < 25; i++) begin
            a = base + 10'(i);
            esp = (i < n) ? a[7:0] : 8'h00;
            comprobar($sformatf("slot%0d", i), {24'd0, coeficientes[i*8 +: 8]}, {24'd0, esp});
        end
    endtask

    task automatic verificar_reposo(input string tag);
        comprobar({tag, "_lectura"}, {31'd0, mem_lectura}, 32'd0);
        comprobar({tag, "_direccion"}, {22'd0, mem_direccion}, 32'd0);
        comprobar({tag, "_banco"}, {31'd0, |coeficientes}, 32'd0);
        comprobar({tag, "_lista"}, {31'd0, mascara_lista}, 32'd0);
        comprobar({tag, "_ocupado"}, {31'd0, ocupado}, 32'd0);
        comprobar({tag, "_error"}, {31'd0, error_tamano}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        inicio = 1'b0;
        direccion_mem_inicio_mascara = '0;
        tamano_mascara = '0;
        repeat (3) @(negedge clk);
        verificar_reposo("reset");
        #1;
        reset = 1'b0;

        // 3x3 fetch
        disparar(10'h010, 3'd3);
        esperar_lista(9, 1'b0);
        verificar_banco(10'h010, 9);

        // Re-trigger from LISTO with a 5x5 that wraps past the top of memory
        disparar(10'h3F0, 3'd5);
        esperar_lista(25, 1'b1);
        verificar_banco(10'h3F0, 25);

        // Illegal size
        disparar(10'h050, 3'd4);
        @(negedge clk);
        comprobar("error_pulso", {31'd0, error_tamano}, 32'd1);
        comprobar("error_lista", {31'd0, mascara_lista}, 32'd0);
        comprobar("error_ocupado", {31'd0, ocupado}, 32'd0);
        comprobar("error_banco", {31'd0, |coeficientes}, 32'd0);
        @(negedge clk);
        comprobar("error_un_ciclo", {31'd0, error_tamano}, 32'd0);
        repeat (3) @(negedge clk);
        comprobar("error_sin_lecturas", lecturas, 0);

        // Restart on the 4th read cycle
        disparar(10'h100, 3'd5);
        repeat (3) @(negedge clk);
        disparar(10'h200, 3'd5);
        esperar_lista(25, 1'b0);
        verificar_banco(10'h200, 25);

        // Reset during the 5th read
        disparar(10'h080, 3'd3);
        repeat (4) @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        exp_dir.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        verificar_reposo("reset_medio");
        lecturas = 0;
        repeat (4) @(negedge clk);
        comprobar("reset_sin_lecturas", lecturas, 0);

        disparar(10'h020, 3'd3);
        esperar_lista(9, 1'b0);
        verificar_banco(10'h020, 9);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errores);
        $finish;
    end

endmodule

// File: doc/lector_mascara.md
Name: lector_mascara

Overview:
- Consumer side of the mask-programming path: on a start pulse, fetches the convolution mask coefficients from mask memory, beginning at the programmed start address.
- Reads tamano_mascara squared words (9 or 25) and holds them in a packed coefficient bank for the filter datapath.
- Driven by the address-change pulse and the start-address/size registers of the mask-control block. Master of a single-port synchronous-read memory.

Parameters:
- BITS_DIRECCION_MEM, 10, width of mask memory address.
- BITS_MASCARA, 3, width of mask size field (legal values 3 and 5).
- BITS_DATO, 8, width of one coefficient / memory word.
- MAX_COEFICIENTES, 25, number of slots in the coefficient bank (5x5).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- inicio  in  1  one-cycle start pulse (mask address changed).
- direccion_mem_inicio_mascara  in  BITS_DIRECCION_MEM  first coefficient address.
- tamano_mascara  in  BITS_MASCARA  mask side length, 3 or 5.
- mem_direccion  out  BITS_DIRECCION_MEM  memory read address.
- mem_lectura  out  1  memory read enable.
- mem_datos  in  BITS_DATO  read data, valid exactly one cycle after mem_lectura.
- coeficientes  out  MAX_COEFICIENTES*BITS_DATO  packed bank; slot k at bits [k*BITS_DATO +: BITS_DATO], row-major.
- mascara_lista  out  1  level: bank complete and valid.
- ocupado  out  1  level: fetch in progress.
- error_tamano  out  1  one-cycle pulse: inicio with an illegal size.

Behaviour:
- Reset (synchronous, active-high): state REPOSO, all outputs 0, all coefficient slots 0, counters and latched base/size 0. Applies mid-fetch: the next cycle shows the reset state and any in-flight read data is discarded.
- States: REPOSO, LEYENDO, DRENANDO, LISTO.
- inicio is honoured in every state.
  - Latches the base address and size on the same edge.
  - Clears all 25 slots.
  - Clears mascara_lista.
- Legal inicio (size 3 -> N=9, size 5 -> N=25): go to LEYENDO, with read index k=0.
- Illegal inicio (any other size): go to REPOSO and pulse error_tamano for one cycle. Slots are still cleared; no memory reads are issued.
- LEYENDO:
  - Each cycle: mem_lectura=1 and mem_direccion = base+k, modulo 2^BITS_DIRECCION_MEM (wrap 0x3FF -> 0x000); then k increments.
  - After issuing k=N-1, go to DRENANDO.
  - ocupado=1.
- Capture pipeline:
  - A registered copy of mem_lectura and of k qualifies mem_datos.
  - On each edge where the copy is 1, write mem_datos into slot k_delayed.
- DRENANDO: one cycle with no read; the last word is captured. Then go to LISTO. ocupado=1.
- LISTO: mascara_lista=1, ocupado=0. The bank holds until the next inicio or reset.
- Timing:
  - inicio is sampled at edge E0.
  - Reads are issued in cycles 1..N.
  - mascara_lista is first high in the cycle after edge E(N+1). For a 3x3 mask, 10 edges after E0 and exactly 9 read cycles.
- 3x3 mask: slots 9..24 remain 0.
- inicio during LEYENDO or DRENANDO aborts the fetch and restarts with the new base/size on the same edge. The delayed capture of the aborted read is suppressed.
- inicio coincident with reset: reset wins.
- mem_lectura is never asserted outside LEYENDO.

Decomposition:
- Shared package:
  - state encoding (REPOSO, LEYENDO, DRENANDO, LISTO);
  - constants TAM_MASCARA_3=3, TAM_MASCARA_5=5, NUM_COEF_3=9, NUM_COEF_5=25.
- Sub-module banco_coeficientes:
  - MAX_COEFICIENTES x BITS_DATO register bank;
  - ports: clear, write enable, write index, write data, packed output.
- Base and size latches reuse the existing enabled D flip-flop register.

Test Plan:
- 3x3 fetch: memory word = address low byte; size 3, base 0x010 -> mem_lectura high for exactly 9 cycles at 0x010..0x018. Slots 0..8 = 0x10..0x18, slots 9..24 = 0, and mascara_lista rises 10 edges after inicio.
- 5x5 with wrap: size 5, base 0x3F0 -> addresses 0x3F0..0x3FF then 0x000..0x008. All 25 slots are correct; mascara_lista rises 26 edges after inicio.
- Illegal size: size 4 -> error_tamano high for exactly one cycle, mem_lectura never high, mascara_lista=0, state REPOSO.
- Restart: size 5 at 0x100, then a new inicio at 0x200 on the 4th read cycle -> reads switch to 0x200 on the next cycle. Slots hold only 0x200-series data; no 0x103 data is written.
- Reset mid-fetch: assert reset during the 5th read -> the next cycle shows all outputs 0 and no further reads. A subsequent inicio completes normally.
- Re-trigger from LISTO: after a completed 3x3 fetch, inicio with size 5 -> mascara_lista drops on the next cycle, the bank clears, and the 25-word fetch completes.
